instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter NUM_WORDS, default 64: instruction words captured per load; 64 words of 4 bytes = 256 bytes.
REQ-002 Parameter ADDR_W, default 6: word-address width; ADDR_W SHALL equal clog2(NUM_WORDS).
REQ-003 sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 sys_reset  input  1  asynchronous, active-high reset.
REQ-005 instr_i  input  8  instruction byte stream, one byte per cycle, most-significant byte of each word first.
REQ-006 imem_we  output  1  instruction-memory write strobe, one cycle wide.
REQ-007 imem_addr  output  ADDR_W  word address for the write.
REQ-008 imem_wdata  output  32  assembled instruction word.
REQ-009 cpu_hold  output  1  holds the downstream core in reset while loading.
REQ-010 load_done  output  1  stays high once all NUM_WORDS words are written.
REQ-011 word_cnt  output  ADDR_W+1  number of words written so far (0..NUM_WORDS).

Function
REQ-012 FSM states: LOAD, FLUSH, RUN; reset state LOAD.
REQ-013 LOAD: capture instr_i on every rising edge, starting with the first edge after sys_reset deasserts; no valid qualifier.
REQ-014 Byte assembly: 2-bit byte index b.
  - b=0 -> instr_i goes to bits [31:24]; b=1 -> [23:16]; b=2 -> [15:8]; b=3 -> [7:0].
  - b wraps 3->0.
REQ-015 On the edge that captures b=3, in the following cycle:
  - imem_we=1 for exactly that cycle;
  - imem_wdata = the four bytes just captured;
  - imem_addr = current word index.
  - Latency: last byte in -> write visible 1 cycle later.
REQ-016 Word index increments after each write; word_cnt = number of completed writes.
REQ-017 When the write with imem_addr = NUM_WORDS-1 is issued:
  - go LOAD->FLUSH;
  - word index SHALL NOT wrap to 0 and issue a further write.
REQ-018 FLUSH lasts exactly 1 cycle, no write; then go to RUN.
REQ-019 In RUN:
  - cpu_hold=0 and load_done=1;
  - instr_i is ignored and imem_we stays 0 until reset.
REQ-020 cpu_hold=1 in LOAD and FLUSH, so the core leaves reset one cycle after the final write is committed.
REQ-021 imem_wdata and imem_addr hold their last written values when imem_we=0.
REQ-022 Bytes arriving in the FLUSH cycle are discarded.
REQ-023 Reset asserted mid-load: the partial word is discarded, no write is issued, and loading restarts at address 0, byte index 0.

Reset
REQ-024 While sys_reset=1, independent of sys_clk:
  - state=LOAD, b=0, word index=0, word_cnt=0;
  - imem_we=0, imem_addr=0, imem_wdata=0;
  - cpu_hold=1, load_done=0.
REQ-025 No output SHALL glitch high on reset release; the first possible imem_we is 4 edges plus 1 cycle after release.

Structure
REQ-026 A shared package holds:
  - the FSM state enum (LOAD, FLUSH, RUN);
  - localparam BYTES_PER_WORD=4;
  - localparam INSTR_W=32.
REQ-027 One sub-module, byte_packer, holds the byte shift/assembly register and the index b. The FSM and counters live in instr_loader.
REQ-028 Fully synchronous datapath except the asynchronous reset; no latches, no combinational path from instr_i to any output.

Verification
REQ-029 Stream 256 bytes 00,01,...,FF after reset -> 64 writes:
  - addr 0 data 00010203;
  - addr 63 data FCFDFEFF;
  - load_done=1 and cpu_hold=0 two cycles after the last byte.
REQ-030 Stream bytes 13,00,50,00 (first word) -> imem_wdata=13005000 at imem_addr 0, imem_we high for exactly 1 cycle.
REQ-031 Assert sys_reset after 130 bytes (word 32, b=2), release, then stream 256 bytes AA -> no write with the partial word; first write is addr 0 data AAAAAAAA; 64 writes total.
REQ-032 After load_done, drive 50 more bytes FF -> imem_we stays 0, word_cnt stays 64, imem_addr stays 63.
REQ-033 Assert sys_reset in RUN, between clock edges -> cpu_hold=1, load_done=0, word_cnt=0 immediately, without waiting for a clock edge.
REQ-034 Checker on every write: imem_addr strictly increments by 1 from 0 to 63, and there are exactly 4 clocks between consecutive imem_we pulses.

Source files
------------

// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and constants for the instruction loader
package instr_loader_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int INSTR_W        = 32;

endpackage

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - instruction-memory write bus
interface instr_loader_if #(
    parameter int ADDR_W = 6
) ();
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        input imem_we,
        input imem_addr,
        input imem_wdata
    );
endinterface

// File: rtl/instr_loader_byte_packer.sv
// rtl/instr_loader_byte_packer.sv - assembles MSB-first bytes into instruction words
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [7:0]         data_byte,
    output logic               word_ready,
    output logic [INSTR_W-1:0] word
);
    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0]   b;
    logic [INSTR_W-9:0] shift_reg;

    // Earlier bytes shift toward the MSB, so byte 0 lands in [31:24] once byte 3 arrives.
    assign word       = {shift_reg, data_byte};
    assign word_ready = en && (b == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b         <= '0;
            shift_reg <= '0;
        end else if (en) begin
            b         <= b + 1'b1;
            shift_reg <= {shift_reg[INSTR_W-17:0], data_byte};
        end
    end
endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - streams a boot image into instruction memory, then releases the core
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int NUM_WORDS = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic [7:0]        instr_i,
    instr_loader_if.master    imem,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   word_cnt
);
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t             state, state_next;
    logic               packer_en;
    logic               word_ready;
    logic [INSTR_W-1:0] packed_word;

    // Once the last word is captured, stop sampling so the index can never wrap.
    assign packer_en = (state == LOAD) && (word_cnt != FULL_CNT);

    byte_packer u_packer (
        .clk        (sys_clk),
        .rst        (sys_reset),
        .en         (packer_en),
        .data_byte  (instr_i),
        .word_ready (word_ready),
        .word       (packed_word)
    );

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (imem.imem_we && (imem.imem_addr == LAST_ADDR)) state_next = FLUSH;
            FLUSH:   state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = LOAD;
        endcase
    end

    // Status flags are registered from the next state so they never glitch.
    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state     <= LOAD;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
        end else begin
            state     <= state_next;
            cpu_hold  <= (state_next != RUN);
            load_done <= (state_next == RUN);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            imem.imem_we    <= 1'b0;
            imem.imem_addr  <= '0;
            imem.imem_wdata <= '0;
            word_cnt        <= '0;
        end else begin
            imem.imem_we <= word_ready;
            if (word_ready) begin
                imem.imem_addr  <= word_cnt[ADDR_W-1:0];
                imem.imem_wdata <= packed_word;
                word_cnt        <= word_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader
module tb_instr_loader;
    localparam int NUM_WORDS = 64;
    localparam int ADDR_W    = 6;
    localparam int NUM_BYTES = NUM_WORDS * 4;

    logic              sys_clk   = 1'b0;
    logic              sys_reset = 1'b1;
    logic [7:0]        instr_i   = 8'h00;
    logic              cpu_hold;
    logic              load_done;
    logic [ADDR_W:0]   word_cnt;

    instr_loader_if #(.ADDR_W(ADDR_W)) imem_bus ();

    instr_loader #(.NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W)) dut (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .instr_i   (instr_i),
        .imem      (imem_bus),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .word_cnt  (word_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int         vectors     = 0;
    int         miscompares = 0;
    int         n           = 0;
    int         prev_we_n   = -1;
    int         prev_addr   = 0;
    int         writes      = 0;
    logic [7:0] hist [NUM_BYTES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: after edge n, words 0..min(n,256)/4-1 are written; the write of word k
    // is visible after edge 4k+4; the core is released after edge 258.
    task automatic verify();
        int          cap;
        int          k;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        cap      = (n > NUM_BYTES) ? NUM_BYTES : n;
        k        = cap / 4;
        exp_we   = (n % 4 == 0) && (n >= 4) && (n <= NUM_BYTES);
        exp_addr = (k > 0) ? 32'(k - 1) : 32'd0;
        exp_data = (k > 0) ? {hist[4*k-4], hist[4*k-3], hist[4*k-2], hist[4*k-1]} : 32'd0;
        check("imem_we",    32'(imem_bus.imem_we),    32'(exp_we));
        check("imem_addr",  32'(imem_bus.imem_addr),  exp_addr);
        check("imem_wdata", imem_bus.imem_wdata,      exp_data);
        check("word_cnt",   32'(word_cnt),            32'(k));
        check("cpu_hold",   32'(cpu_hold),            32'(n < NUM_BYTES + 2));
        check("load_done",  32'(load_done),           32'(n >= NUM_BYTES + 2));
        if (imem_bus.imem_we === 1'b1) begin
            writes++;
            if (prev_we_n < 0) begin
                check("first_addr", 32'(imem_bus.imem_addr), 32'd0);
            end else begin
                check("we_spacing", 32'(n - prev_we_n), 32'd4);
                check("addr_step", 32'(imem_bus.imem_addr), 32'(prev_addr + 1));
            end
            prev_we_n = n;
            prev_addr = int'(imem_bus.imem_addr);
        end
    endtask

    task automatic step(input logic [7:0] b);
        instr_i = b;
        @(posedge sys_clk);
        if (n < NUM_BYTES) hist[n] = b;
        n++;
        @(negedge sys_clk);
        verify();
    endtask

    // Reset is raised between edges and checked before any clock edge arrives.
    task automatic do_reset();
        @(negedge sys_clk);
        #1;
        sys_reset = 1'b1;
        #2;
        check("rst_cpu_hold",  32'(cpu_hold),            32'd1);
        check("rst_load_done", 32'(load_done),           32'd0);
        check("rst_word_cnt",  32'(word_cnt),            32'd0);
        check("rst_imem_we",   32'(imem_bus.imem_we),    32'd0);
        check("rst_imem_addr", 32'(imem_bus.imem_addr),  32'd0);
        check("rst_imem_wdata", imem_bus.imem_wdata,     32'd0);
        @(negedge sys_clk);
        sys_reset = 1'b0;
        n         = 0;
        prev_we_n = -1;
        prev_addr = 0;
        writes    = 0;
        for (int i = 0; i < NUM_BYTES; i++) hist[i] = 8'h00;
    endtask

    initial begin
        int cut;
        for (int i = 0; i < NUM_BYTES; i++) hist[i] = 8'h00;

        // Incrementing image, then trailing bytes after completion.
        do_reset();
        for (int i = 0; i < NUM_BYTES; i++) begin
            step(8'(i));
            if (i == 3) check("first_word", imem_bus.imem_wdata, 32'h00010203);
        end
        check("last_we", 32'(imem_bus.imem_we), 32'd1);
        check("last_word", imem_bus.imem_wdata, 32'hFCFDFEFF);
        check("last_addr", 32'(imem_bus.imem_addr), 32'd63);
        step(8'hFF);
        check("hold_in_flush", 32'(cpu_hold), 32'd1);
        step(8'hFF);
        check("done_after_2", 32'(load_done), 32'd1);
        check("released_after_2", 32'(cpu_hold), 32'd0);
        for (int i = 0; i < 48; i++) step(8'hFF);
        check("run_word_cnt", 32'(word_cnt), 32'd64);
        check("run_addr", 32'(imem_bus.imem_addr), 32'd63);
        check("writes_a", 32'(writes), 32'd64);

        // Reset from RUN, then a known first word followed by random bytes.
        do_reset();
        step(8'h13); step(8'h00); step(8'h50); step(8'h00);
        check("word_1300", imem_bus.imem_wdata, 32'h13005000);
        check("word_1300_we", 32'(imem_bus.imem_we), 32'd1);
        step(8'($urandom));
        check("we_one_cycle", 32'(imem_bus.imem_we), 32'd0);
        for (int i = 0; i < NUM_BYTES; i++) step(8'($urandom));
        check("writes_b", 32'(writes), 32'd64);

        // Reset at word 32 byte 2, then a constant image.
        do_reset();
        for (int i = 0; i < 130; i++) step(8'($urandom));
        do_reset();
        for (int i = 0; i < NUM_BYTES + 2; i++) begin
            step(8'hAA);
            if (i == 3) begin
                check("aa_first_addr", 32'(imem_bus.imem_addr), 32'd0);
                check("aa_first_word", imem_bus.imem_wdata, 32'hAAAAAAAA);
            end
        end
        check("writes_c", 32'(writes), 32'd64);

        // Reset at a random point, then a fully random image.
        do_reset();
        cut = int'($urandom_range(5, 250));
        for (int i = 0; i < cut; i++) step(8'($urandom));
        do_reset();
        for (int i = 0; i < NUM_BYTES + 6; i++) step(8'($urandom));
        check("writes_d", 32'(writes), 32'd64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
